// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous 2-D position controller for a single hardware sprite.
// Takes at most one step per frame from four level direction requests, with
// per-axis wrap or clamp at the bounds. An update that arrives while the
// renderer is busy is held back until it is free. hstart/vstart tell the
// renderer when the raster reaches the sprite position.
//
// state   | meaning
// --------+---------------------------------------------------------------
// WAIT    | idle; on a tick (or a deferred tick) with hold low, latch dx/dy
// APPLY_X | step pos_x by the latched dx
// APPLY_Y | step pos_y by the latched dy, pulse moved if anything changed
module sprite_motion_ctrl #(
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int INIT_X  = 256,
    parameter int INIT_Y  = 400,
    parameter int MIN_X   = 160,
    parameter int MAX_X   = 320,
    parameter int MIN_Y   = 240,
    parameter int MAX_Y   = 464,
    parameter int SPEED_X = 15,
    parameter int SPEED_Y = 8,
    parameter bit WRAP_X  = 1'b1,
    parameter bit WRAP_Y  = 1'b0
) (
    input  logic           SYS_CLK,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           mv_left,
    input  logic           mv_right,
    input  logic           mv_up,
    input  logic           mv_down,
    input  logic           hold,
    input  logic [X_W-1:0] raster_x,
    input  logic [Y_W-1:0] raster_y,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           hstart,
    output logic           vstart,
    output logic           moved
);

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        APPLY_X = 2'd1,
        APPLY_Y = 2'd2
    } state_t;

    // Thresholds are one bit wider than the position so that MAX-SPEED and
    // MIN+SPEED cannot wrap around, whatever the parameter values.
    localparam logic [X_W:0]   X_UP_LIM = (X_W+1)'(MAX_X - SPEED_X);
    localparam logic [X_W:0]   X_DN_LIM = (X_W+1)'(MIN_X + SPEED_X);
    localparam logic [Y_W:0]   Y_UP_LIM = (Y_W+1)'(MAX_Y - SPEED_Y);
    localparam logic [Y_W:0]   Y_DN_LIM = (Y_W+1)'(MIN_Y + SPEED_Y);
    localparam logic [X_W-1:0] X_MIN_V  = X_W'(MIN_X);
    localparam logic [X_W-1:0] X_MAX_V  = X_W'(MAX_X);
    localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(MIN_Y);
    localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(MAX_Y);
    localparam logic [X_W-1:0] X_SPD    = X_W'(SPEED_X);
    localparam logic [Y_W-1:0] Y_SPD    = Y_W'(SPEED_Y);

    state_t         state;
    state_t         state_next;
    logic           pending;
    logic           start_upd;
    logic           dx_inc;
    logic           dx_dec;
    logic           dy_inc;
    logic           dy_dec;
    logic [X_W-1:0] latch_x;
    logic [Y_W-1:0] latch_y;
    logic [X_W-1:0] x_step;
    logic [Y_W-1:0] y_step;

    // State register; reset abandons any half-applied update.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one pass through X then Y per accepted update.
    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (start_upd) state_next = APPLY_X;
            APPLY_X: state_next = APPLY_Y;
            APPLY_Y: state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Output decode: an update starts on a fresh or deferred tick once the renderer is free.
    always_comb begin
        start_upd = (state == WAIT) && !hold && (frame_tick || pending);
    end

    // Candidate new X: wrap or clamp when the step would cross a bound.
    always_comb begin
        x_step = pos_x;
        if (dx_inc) begin
            if ({1'b0, pos_x} > X_UP_LIM) begin
                x_step = WRAP_X ? X_MIN_V : X_MAX_V;
            end else begin
                x_step = pos_x + X_SPD;
            end
        end else if (dx_dec) begin
            if ({1'b0, pos_x} < X_DN_LIM) begin
                x_step = WRAP_X ? X_MAX_V : X_MIN_V;
            end else begin
                x_step = pos_x - X_SPD;
            end
        end
    end

    // Candidate new Y, same rules as X with the Y bounds.
    always_comb begin
        y_step = pos_y;
        if (dy_inc) begin
            if ({1'b0, pos_y} > Y_UP_LIM) begin
                y_step = WRAP_Y ? Y_MIN_V : Y_MAX_V;
            end else begin
                y_step = pos_y + Y_SPD;
            end
        end else if (dy_dec) begin
            if ({1'b0, pos_y} < Y_DN_LIM) begin
                y_step = WRAP_Y ? Y_MAX_V : Y_MIN_V;
            end else begin
                y_step = pos_y - Y_SPD;
            end
        end
    end

    // Datapath: latch the request, step X then Y, and track the deferred tick.
    always_ff @(posedge SYS_CLK) begin
        if (reset) begin
            pos_x   <= X_W'(INIT_X);
            pos_y   <= Y_W'(INIT_Y);
            moved   <= 1'b0;
            pending <= 1'b0;
            dx_inc  <= 1'b0;
            dx_dec  <= 1'b0;
            dy_inc  <= 1'b0;
            dy_dec  <= 1'b0;
            latch_x <= '0;
            latch_y <= '0;
        end else begin
            moved <= 1'b0;
            case (state)
                WAIT: begin
                    if (start_upd) begin
                        // Opposing requests cancel to no motion on that axis.
                        dx_inc  <= mv_right & ~mv_left;
                        dx_dec  <= mv_left & ~mv_right;
                        dy_inc  <= mv_down & ~mv_up;
                        dy_dec  <= mv_up & ~mv_down;
                        latch_x <= pos_x;
                        latch_y <= pos_y;
                        pending <= 1'b0;
                    end else if (frame_tick && hold) begin
                        pending <= 1'b1;
                    end
                end
                APPLY_X: begin
                    pos_x <= x_step;
                end
                APPLY_Y: begin
                    pos_y <= y_step;
                    moved <= (pos_x != latch_x) || (y_step != latch_y);
                end
                default: ;
            endcase
        end
    end

    assign hstart = (raster_x == pos_x);
    assign vstart = (raster_y == pos_y);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl with the default parameter set.
module tb_sprite_motion_ctrl;

    logic       SYS_CLK = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       mv_left = 1'b0;
    logic       mv_right = 1'b0;
    logic       mv_up = 1'b0;
    logic       mv_down = 1'b0;
    logic       hold = 1'b0;
    logic [9:0] raster_x = '0;
    logic [8:0] raster_y = '0;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       hstart;
    logic       vstart;
    logic       moved;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_motion_ctrl dut (
        .SYS_CLK    (SYS_CLK),
        .reset      (reset),
        .frame_tick (frame_tick),
        .mv_left    (mv_left),
        .mv_right   (mv_right),
        .mv_up      (mv_up),
        .mv_down    (mv_down),
        .hold       (hold),
        .raster_x   (raster_x),
        .raster_y   (raster_y),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .hstart     (hstart),
        .vstart     (vstart),
        .moved      (moved)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        logic [3:0] mv;   // {left, right, up, down}
        int         exp_x;
        int         exp_y;
        logic       exp_moved;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame tick with the given requests; checks the N+1/N+2/N+3 timing.
    task automatic run_frame(input string name, input logic [3:0] mv,
                             input int ex, input int ey, input logic em, input int prev_y);
        @(negedge SYS_CLK);
        {mv_left, mv_right, mv_up, mv_down} = mv;
        frame_tick = 1'b1;
        @(negedge SYS_CLK);
        frame_tick = 1'b0;
        @(negedge SYS_CLK);
        chk({name, " pos_x@N+1"}, int'(pos_x), ex);
        chk({name, " pos_y@N+1"}, int'(pos_y), prev_y);
        chk({name, " moved@N+1"}, int'(moved), 0);
        @(negedge SYS_CLK);
        chk({name, " pos_y@N+2"}, int'(pos_y), ey);
        chk({name, " moved@N+2"}, int'(moved), int'(em));
        @(negedge SYS_CLK);
        chk({name, " moved@N+3"}, int'(moved), 0);
        {mv_left, mv_right, mv_up, mv_down} = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge SYS_CLK);
        reset = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        reset = 1'b0;
    endtask

    initial begin
        int prev_y;

        vecs[0]  = '{4'b0100, 271, 400, 1'b1};
        vecs[1]  = '{4'b0100, 286, 400, 1'b1};
        vecs[2]  = '{4'b0100, 301, 400, 1'b1};
        vecs[3]  = '{4'b0100, 316, 400, 1'b1};
        vecs[4]  = '{4'b0100, 160, 400, 1'b1};   // 316 > 305: wrap to MIN_X
        vecs[5]  = '{4'b1000, 320, 400, 1'b1};   // 160 < 175: wrap to MAX_X
        vecs[6]  = '{4'b1000, 305, 400, 1'b1};
        vecs[7]  = '{4'b0100, 320, 400, 1'b1};   // 305 == MAX-SPEED: plain step
        vecs[8]  = '{4'b1110, 320, 392, 1'b1};   // left+right cancel, up steps
        vecs[9]  = '{4'b1111, 320, 392, 1'b0};
        vecs[10] = '{4'b0000, 320, 392, 1'b0};
        vecs[11] = '{4'b0001, 320, 400, 1'b1};
        vecs[12] = '{4'b0001, 320, 408, 1'b1};
        vecs[13] = '{4'b0001, 320, 416, 1'b1};
        vecs[14] = '{4'b0001, 320, 424, 1'b1};
        vecs[15] = '{4'b0001, 320, 432, 1'b1};
        vecs[16] = '{4'b0001, 320, 440, 1'b1};
        vecs[17] = '{4'b0001, 320, 448, 1'b1};
        vecs[18] = '{4'b0001, 320, 456, 1'b1};
        vecs[19] = '{4'b0001, 320, 464, 1'b1};   // 456 == MAX-SPEED: plain step
        vecs[20] = '{4'b0001, 320, 464, 1'b0};   // clamp, no change
        vecs[21] = '{4'b1001, 305, 464, 1'b1};

        do_reset();
        @(negedge SYS_CLK);
        chk("reset pos_x", int'(pos_x), 256);
        chk("reset pos_y", int'(pos_y), 400);
        chk("reset moved", int'(moved), 0);

        raster_x = 10'd256;
        raster_y = 9'd399;
        #1;
        chk("hstart match", int'(hstart), 1);
        chk("vstart miss", int'(vstart), 0);
        raster_x = 10'd257;
        raster_y = 9'd400;
        #1;
        chk("hstart miss", int'(hstart), 0);
        chk("vstart match", int'(vstart), 1);

        prev_y = 400;
        for (int i = 0; i < 22; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].mv, vecs[i].exp_x,
                      vecs[i].exp_y, vecs[i].exp_moved, prev_y);
            prev_y = vecs[i].exp_y;
        end

        // Deferred update: two ticks under hold collapse into one step.
        do_reset();
        @(negedge SYS_CLK);
        hold = 1'b1;
        mv_right = 1'b1;
        frame_tick = 1'b1;
        @(negedge SYS_CLK);
        frame_tick = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        frame_tick = 1'b1;
        @(negedge SYS_CLK);
        frame_tick = 1'b0;
        repeat (12) @(negedge SYS_CLK);
        chk("hold pos_x blocked", int'(pos_x), 256);
        chk("hold moved blocked", int'(moved), 0);
        hold = 1'b0;
        @(negedge SYS_CLK);
        chk("hold release +1 pos_x", int'(pos_x), 256);
        @(negedge SYS_CLK);
        chk("hold release +2 pos_x", int'(pos_x), 271);
        @(negedge SYS_CLK);
        chk("hold release +3 moved", int'(moved), 1);
        mv_right = 1'b0;
        repeat (6) @(negedge SYS_CLK);
        chk("hold single step pos_x", int'(pos_x), 271);
        chk("hold single step moved", int'(moved), 0);

        // Reset while the FSM sits in APPLY_Y discards the update.
        @(negedge SYS_CLK);
        mv_right = 1'b1;
        frame_tick = 1'b1;
        @(negedge SYS_CLK);
        frame_tick = 1'b0;
        @(negedge SYS_CLK);
        chk("midreset pre pos_x", int'(pos_x), 286);
        reset = 1'b1;
        @(negedge SYS_CLK);
        chk("midreset pos_x", int'(pos_x), 256);
        chk("midreset pos_y", int'(pos_y), 400);
        chk("midreset moved", int'(moved), 0);
        reset = 1'b0;
        mv_right = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        chk("midreset idle moved", int'(moved), 0);
        run_frame("post-reset", 4'b0100, 271, 400, 1'b1, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
